commit_stage: RTL

//  Final pipeline stage, directly downstream of the execute stage. Consumes the executed op and its results.

---
 rtl/commit_stage_pkg.sv | 26 ++
 rtl/commit_stage_instret_counter.sv | 36 +++
 rtl/commit_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/commit_stage_pkg.sv
// Shared types and default widths for the commit stage.
package commit_stage_pkg;

  localparam int unsigned Xlen     = 32;
  localparam int unsigned Flen     = 64;
  localparam int unsigned RegW     = 5;
  localparam int unsigned InstretW = 64;
  localparam int unsigned CauseW   = 5;

  typedef enum logic [1:0] {
    StIdle,
    StWaitAck,
    StFlush
  } commit_state_e;

  typedef struct packed {
    logic       is_interrupt;
    logic [3:0] code;
  } trap_cause_t;

  // x0 is hardwired to zero, so writes to it are dropped.
  function automatic logic int_write_allowed(input logic we, input logic [RegW-1:0] rd);
    return we && (rd != '0);
  endfunction

endpackage

// File: rtl/commit_stage_instret_counter.sv
// Free-running event counter with a CSR write port; a write wins over an increment.
module commit_stage_instret_counter #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             we_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_d, count_q;

  // Next count: CSR write has priority, increment wraps naturally.
  always_comb begin
    count_d = count_q;
    if (we_i) begin
      count_d = wdata_i;
    end else if (inc_i) begin
      count_d = count_q + Width'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/commit_stage.sv
// Commit stage: retires ops into the RF write ports, counts retired instructions and
// sequences traps / trap returns with the CSR unit before flushing to the new PC.
module commit_stage
  import commit_stage_pkg::*;
#(
  parameter int unsigned Xlen     = commit_stage_pkg::Xlen,
  parameter int unsigned Flen     = commit_stage_pkg::Flen,
  parameter int unsigned RegW     = commit_stage_pkg::RegW,
  parameter int unsigned InstretW = commit_stage_pkg::InstretW
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  input  logic [Xlen-1:0]     in_pc_i,
  input  logic [RegW-1:0]     in_rd_i,
  input  logic                in_int_we_i,
  input  logic                in_fp_we_i,
  input  logic [Xlen-1:0]     in_int_value_i,
  input  logic [Flen-1:0]     in_fp_value_i,
  input  logic                in_trap_valid_i,
  input  logic [CauseW-1:0]   in_trap_cause_i,
  input  logic [Xlen-1:0]     in_trap_value_i,
  input  logic                in_trap_return_i,
  input  logic                csr_ack_i,
  input  logic [Xlen-1:0]     csr_target_i,
  input  logic                instret_we_i,
  input  logic [InstretW-1:0] instret_wdata_i,
  output logic                int_rf_we_o,
  output logic [RegW-1:0]     int_rf_addr_o,
  output logic [Xlen-1:0]     int_rf_data_o,
  output logic                fp_rf_we_o,
  output logic [RegW-1:0]     fp_rf_addr_o,
  output logic [Flen-1:0]     fp_rf_data_o,
  output logic                trap_req_o,
  output logic                trap_ret_req_o,
  output logic [Xlen-1:0]     trap_pc_o,
  output logic [CauseW-1:0]   trap_cause_o,
  output logic [Xlen-1:0]     trap_value_o,
  output logic                stall_req_o,
  output logic                flush_req_o,
  output logic [Xlen-1:0]     flush_target_o,
  output logic [InstretW-1:0] instret_o
);

  commit_state_e state_q;

  logic            int_rf_we_q, fp_rf_we_q;
  logic [RegW-1:0] int_rf_addr_q, fp_rf_addr_q;
  logic [Xlen-1:0] int_rf_data_q;
  logic [Flen-1:0] fp_rf_data_q;
  logic            trap_req_q, trap_ret_req_q;
  logic [Xlen-1:0] trap_pc_q, trap_value_q;
  trap_cause_t     trap_cause_q;
  logic            flush_req_q;
  logic [Xlen-1:0] flush_target_q;

  logic is_exc, retire, ret_done;

  // Decode what the current cycle does to the architectural state.
  always_comb begin
    is_exc   = in_trap_valid_i || in_trap_return_i;
    retire   = (state_q == StIdle) && in_valid_i && !is_exc;
    // A trap return counts as retired once the CSR accepts it; a trap never does.
    ret_done = (state_q == StWaitAck) && csr_ack_i && trap_ret_req_q;
  end

  // Control FSM with registered RF strobes, CSR requests and flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      int_rf_we_q    <= 1'b0;
      int_rf_addr_q  <= '0;
      int_rf_data_q  <= '0;
      fp_rf_we_q     <= 1'b0;
      fp_rf_addr_q   <= '0;
      fp_rf_data_q   <= '0;
      trap_req_q     <= 1'b0;
      trap_ret_req_q <= 1'b0;
      trap_pc_q      <= '0;
      trap_cause_q   <= '0;
      trap_value_q   <= '0;
      flush_req_q    <= 1'b0;
      flush_target_q <= '0;
    end else begin
      // Strobes are single-cycle pulses unless re-armed below.
      int_rf_we_q <= 1'b0;
      fp_rf_we_q  <= 1'b0;
      flush_req_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid_i && is_exc) begin
            state_q        <= StWaitAck;
            trap_req_q     <= in_trap_valid_i;
            trap_ret_req_q <= !in_trap_valid_i;
            trap_pc_q      <= in_pc_i;
            trap_cause_q   <= trap_cause_t'(in_trap_cause_i);
            trap_value_q   <= in_trap_value_i;
          end else if (retire) begin
            int_rf_we_q   <= int_write_allowed(in_int_we_i, in_rd_i);
            fp_rf_we_q    <= in_fp_we_i;
            int_rf_addr_q <= in_rd_i;
            fp_rf_addr_q  <= in_rd_i;
            int_rf_data_q <= in_int_value_i;
            fp_rf_data_q  <= in_fp_value_i;
          end
        end
        StWaitAck: begin
          if (csr_ack_i) begin
            state_q        <= StFlush;
            trap_req_q     <= 1'b0;
            trap_ret_req_q <= 1'b0;
            flush_req_q    <= 1'b1;
            flush_target_q <= csr_target_i;
          end
        end
        StFlush: begin
          // Whatever arrives now is younger than the redirect and is dropped.
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  commit_stage_instret_counter #(
    .Width (InstretW)
  ) u_instret_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (retire || ret_done),
    .we_i    (instret_we_i),
    .wdata_i (instret_wdata_i),
    .count_o (instret_o)
  );

  assign int_rf_we_o    = int_rf_we_q;
  assign int_rf_addr_o  = int_rf_addr_q;
  assign int_rf_data_o  = int_rf_data_q;
  assign fp_rf_we_o     = fp_rf_we_q;
  assign fp_rf_addr_o   = fp_rf_addr_q;
  assign fp_rf_data_o   = fp_rf_data_q;
  assign trap_req_o     = trap_req_q;
  assign trap_ret_req_o = trap_ret_req_q;
  assign trap_pc_o      = trap_pc_q;
  assign trap_cause_o   = trap_cause_q;
  assign trap_value_o   = trap_value_q;
  assign stall_req_o    = (state_q == StWaitAck);
  assign flush_req_o    = flush_req_q;
  assign flush_target_o = flush_target_q;

endmodule
